// File: rtl/fifo_rd_stream.sv
// Drain stage for the fifo block. It reads words out of the fifo and presents them
// on a valid/ready stream through a 2-entry skid buffer, counting every delivered word.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_op,
    output logic              rd_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t              occ_q, occ_d;
    logic              infl_q, infl_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              cap;
    logic              pop;
    logic              space;

    // A read is only issued when the buffer plus the word in flight still fits,
    // or when a pop this cycle frees the slot the new word will land in.
    always_comb begin
        space = 1'b0;
        case (occ_q)
            OCC_EMPTY: space = 1'b1;
            OCC_ONE:   space = ~infl_q;
            default:   space = 1'b0;
        endcase
        m_valid = (occ_q != OCC_EMPTY);
        m_data  = m_valid ? head_q : '0;
        pop     = m_valid & m_ready;
        cap     = infl_q & ~drop_q;
        rd_en   = ~rst & ~flush & ~empty & (space | pop);
    end

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        infl_d     = rd_en;
        drop_d     = 1'b0;
        word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, pop};
        case (occ_q)
            OCC_EMPTY: begin
                if (cap) begin
                    head_d = data_op;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (cap && pop) begin
                    head_d = data_op;
                end else if (cap) begin
                    tail_d = data_op;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (cap) begin
                        tail_d = data_op;
                    end else begin
                        occ_d  = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // A word already requested when flush hits is marked for discard on arrival.
        if (flush) begin
            occ_d  = OCC_EMPTY;
            drop_d = infl_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= OCC_EMPTY;
            infl_q     <= 1'b0;
            drop_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;

endmodule
